// File: rtl/lcd_pkg.sv
// Shared constants, widths and FSM encoding for the DE-mode LCD receiver.
package lcd_pkg;

  // Nominal panel timing (in pclk cycles / lines)
  localparam int unsigned LCD_H_ACTIVE   = 480;
  localparam int unsigned LCD_V_ACTIVE   = 272;
  localparam int unsigned LCD_H_BLANK    = 256;
  localparam int unsigned LCD_V_BLANK    = 45;
  localparam int unsigned LCD_VBLANK_MIN = 1024;

  // Coordinate and address widths
  localparam int unsigned X_W    = 10;
  localparam int unsigned Y_W    = 9;
  localparam int unsigned ADDR_W = 17;

  typedef enum logic [1:0] {
    StSearch = 2'd0,
    StVblank = 2'd1,
    StLine   = 2'd2,
    StHblank = 2'd3
  } rx_state_e;

endpackage

// File: rtl/lcd_de_rx_if.sv
// LCD bus plus recovered pixel stream. The panel side is master, the receiver is slave.
interface lcd_de_rx_if;
  import lcd_pkg::*;

  logic              pclk_in;
  logic              de_in;
  logic              r_in;
  logic              g_in;
  logic              b_in;
  logic              pix_valid;
  logic [X_W-1:0]    pix_x;
  logic [Y_W-1:0]    pix_y;
  logic [ADDR_W-1:0] pix_addr;
  logic [2:0]        pix_rgb;

  modport master (
    output pclk_in, de_in, r_in, g_in, b_in,
    input  pix_valid, pix_x, pix_y, pix_addr, pix_rgb
  );

  modport slave (
    input  pclk_in, de_in, r_in, g_in, b_in,
    output pix_valid, pix_x, pix_y, pix_addr, pix_rgb
  );

endinterface

// File: rtl/lcd_edge_sync.sv
// Synchronizer chain for the LCD bus and pclk rising-edge detect.
// de/rgb leave the same stage as pclk so they line up with the detected edge.
module lcd_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pclk_i,
  input  logic       de_i,
  input  logic [2:0] rgb_i,
  output logic       pclk_rise_o,
  output logic       de_o,
  output logic [2:0] rgb_o
);

  // Bit 4 = pclk, bit 3 = de, bits 2:0 = rgb
  logic [4:0] sync_q [SYNC_STAGES];
  logic [4:0] sync_d [SYNC_STAGES];
  logic       pclk_prev_q, pclk_prev_d;

  // Shift the bus through the chain and remember the last synchronized pclk
  always_comb begin
    sync_d[0] = {pclk_i, de_i, rgb_i};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    pclk_prev_d = sync_q[SYNC_STAGES-1][4];
  end

  // Synchronizer and edge-history registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      pclk_prev_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      pclk_prev_q <= pclk_prev_d;
    end
  end

  assign pclk_rise_o = sync_q[SYNC_STAGES-1][4] & ~pclk_prev_q;
  assign de_o        = sync_q[SYNC_STAGES-1][3];
  assign rgb_o       = sync_q[SYNC_STAGES-1][2:0];

endmodule

// File: rtl/lcd_de_rx.sv
// DE-mode LCD receiver: recovers pixel coordinates, frame-buffer address and colour,
// measures frame geometry and reports lock / sticky geometry errors.
module lcd_de_rx
  import lcd_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = LCD_H_ACTIVE,
  parameter int unsigned V_ACTIVE    = LCD_V_ACTIVE,
  parameter int unsigned VBLANK_MIN  = LCD_VBLANK_MIN,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  lcd_de_rx_if.slave     bus,
  output logic           frame_done,
  output logic [X_W-1:0] meas_width,
  output logic [Y_W-1:0] meas_height,
  output logic           locked,
  output logic           geom_err
);

  localparam int unsigned       CNT_W    = $clog2(VBLANK_MIN + 1);
  localparam logic [CNT_W-1:0]  CntLimit = CNT_W'(VBLANK_MIN);
  localparam logic [X_W-1:0]    XMax     = '1;
  localparam logic [Y_W-1:0]    YMax     = '1;
  localparam logic [X_W-1:0]    HExp     = X_W'(H_ACTIVE);
  localparam logic [Y_W-1:0]    VExp     = Y_W'(V_ACTIVE);

  logic       pclk_rise;
  logic       de_s;
  logic [2:0] rgb_s;

  lcd_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk         (clk),
    .rst         (rst),
    .pclk_i      (bus.pclk_in),
    .de_i        (bus.de_in),
    .rgb_i       ({bus.r_in, bus.g_in, bus.b_in}),
    .pclk_rise_o (pclk_rise),
    .de_o        (de_s),
    .rgb_o       (rgb_s)
  );

  rx_state_e         state_q, state_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              frame_ok_q, frame_ok_d;
  logic [1:0]        good_cnt_q, good_cnt_d;
  logic              pix_valid_q, pix_valid_d;
  logic [X_W-1:0]    pix_x_q, pix_x_d;
  logic [Y_W-1:0]    pix_y_q, pix_y_d;
  logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
  logic [2:0]        pix_rgb_q, pix_rgb_d;
  logic              frame_done_q, frame_done_d;
  logic [X_W-1:0]    meas_width_q, meas_width_d;
  logic [Y_W-1:0]    meas_height_q, meas_height_d;
  logic              locked_q, locked_d;
  logic              geom_err_q, geom_err_d;
  logic              err_evt;

  // Blank-edge counter saturates so a long stall in blank cannot wrap it
  assign cnt_inc = (cnt_q == CntLimit) ? cnt_q : cnt_q + CNT_W'(1);

  // Next-state, counters and output registers; all updates gated by a pclk edge
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    addr_d        = addr_q;
    line_base_d   = line_base_q;
    cnt_d         = cnt_q;
    frame_ok_d    = frame_ok_q;
    good_cnt_d    = good_cnt_q;
    pix_valid_d   = 1'b0;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    pix_addr_d    = pix_addr_q;
    pix_rgb_d     = pix_rgb_q;
    frame_done_d  = 1'b0;
    meas_width_d  = meas_width_q;
    meas_height_d = meas_height_q;
    locked_d      = locked_q;
    geom_err_d    = geom_err_q;
    err_evt       = 1'b0;

    if (pclk_rise) begin
      unique case (state_q)
        StSearch: begin
          if (de_s) begin
            cnt_d = '0;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CntLimit) state_d = StVblank;
          end
        end
        StVblank: begin
          if (de_s) begin
            pix_valid_d = 1'b1;
            pix_x_d     = '0;
            pix_y_d     = '0;
            pix_addr_d  = '0;
            pix_rgb_d   = rgb_s;
            x_d         = X_W'(1);
            y_d         = '0;
            addr_d      = ADDR_W'(1);
            line_base_d = '0;
            frame_ok_d  = 1'b1;
            state_d     = StLine;
          end
        end
        StLine: begin
          if (de_s) begin
            pix_valid_d = 1'b1;
            pix_x_d     = x_q;
            pix_y_d     = y_q;
            pix_addr_d  = addr_q;
            pix_rgb_d   = rgb_s;
            if (x_q == XMax) begin
              err_evt = 1'b1;
            end else begin
              x_d    = x_q + X_W'(1);
              addr_d = addr_q + ADDR_W'(1);
            end
          end else begin
            meas_width_d = x_q;
            line_base_d  = line_base_q + ADDR_W'(x_q);
            cnt_d        = CNT_W'(1);
            state_d      = StHblank;
            if (x_q != HExp) err_evt = 1'b1;
          end
        end
        StHblank: begin
          if (de_s) begin
            if (y_q == YMax) begin
              err_evt = 1'b1;
            end else begin
              y_d = y_q + Y_W'(1);
            end
            pix_valid_d = 1'b1;
            pix_x_d     = '0;
            pix_y_d     = y_d;
            pix_addr_d  = line_base_q;
            pix_rgb_d   = rgb_s;
            x_d         = X_W'(1);
            addr_d      = line_base_q + ADDR_W'(1);
            state_d     = StLine;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CntLimit) begin
              meas_height_d = (y_q == YMax) ? y_q : y_q + Y_W'(1);
              frame_done_d  = 1'b1;
              state_d       = StVblank;
              if (meas_height_d != VExp) begin
                err_evt = 1'b1;
              end else if (frame_ok_q) begin
                good_cnt_d = (good_cnt_q == 2'd2) ? 2'd2 : good_cnt_q + 2'd1;
                if (good_cnt_d == 2'd2) locked_d = 1'b1;
              end else begin
                good_cnt_d = '0;
              end
            end
          end
        end
        default: state_d = StSearch;
      endcase
    end

    // Any geometry fault breaks the current lock and the good-frame run
    if (err_evt) begin
      geom_err_d = 1'b1;
      locked_d   = 1'b0;
      good_cnt_d = '0;
      frame_ok_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StSearch;
      x_q           <= '0;
      y_q           <= '0;
      addr_q        <= '0;
      line_base_q   <= '0;
      cnt_q         <= '0;
      frame_ok_q    <= 1'b0;
      good_cnt_q    <= '0;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_addr_q    <= '0;
      pix_rgb_q     <= '0;
      frame_done_q  <= 1'b0;
      meas_width_q  <= '0;
      meas_height_q <= '0;
      locked_q      <= 1'b0;
      geom_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      addr_q        <= addr_d;
      line_base_q   <= line_base_d;
      cnt_q         <= cnt_d;
      frame_ok_q    <= frame_ok_d;
      good_cnt_q    <= good_cnt_d;
      pix_valid_q   <= pix_valid_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_addr_q    <= pix_addr_d;
      pix_rgb_q     <= pix_rgb_d;
      frame_done_q  <= frame_done_d;
      meas_width_q  <= meas_width_d;
      meas_height_q <= meas_height_d;
      locked_q      <= locked_d;
      geom_err_q    <= geom_err_d;
    end
  end

  assign bus.pix_valid = pix_valid_q;
  assign bus.pix_x     = pix_x_q;
  assign bus.pix_y     = pix_y_q;
  assign bus.pix_addr  = pix_addr_q;
  assign bus.pix_rgb   = pix_rgb_q;
  assign frame_done    = frame_done_q;
  assign meas_width    = meas_width_q;
  assign meas_height   = meas_height_q;
  assign locked        = locked_q;
  assign geom_err      = geom_err_q;

endmodule

// File: doc/lcd_de_rx.md
Name: lcd_de_rx

Overview:
- Receiver for the DE-mode parallel RGB LCD interface (pclk, de, 1-bit r/g/b) produced by the panel timing generator.
- Oversamples the interface in the system clock and recovers pixel coordinates, a linear frame-buffer address and pixel colour.
- Measures frame geometry and reports sync lock and errors.
- Sits between an external/looped-back LCD bus and a pixel RAM writer or checker.

Parameters:
- H_ACTIVE, 480, expected active pixels per line (DE-high pclks per line).
- V_ACTIVE, 272, expected active lines per frame.
- VBLANK_MIN, 1024, consecutive DE-low pclk edges that mark vertical blanking (must exceed the horizontal blank of 256).
- SYNC_STAGES, 2, synchronizer depth on all bus inputs.

Ports:
- clk  in  1  system clock; must be at least 4x the pclk frequency.
- rst  in  1  synchronous, active-high reset.
- pclk_in  in  1  LCD pixel clock (asynchronous to clk).
- de_in  in  1  data enable.
- r_in, g_in, b_in  in  1 each  pixel colour bits.
- pix_valid  out  1  one-clk strobe per captured active pixel.
- pix_x  out  10  column of the strobed pixel.
- pix_y  out  9  line of the strobed pixel.
- pix_addr  out  17  y*H_ACTIVE + x of the strobed pixel.
- pix_rgb  out  3  {r,g,b} of the strobed pixel.
- frame_done  out  1  one-clk pulse when VBLANK is detected after at least one active line.
- meas_width  out  10  DE-high length of the last completed line.
- meas_height  out  9  line count of the last completed frame.
- locked  out  1  high after two consecutive frames with exactly H_ACTIVE x V_ACTIVE.
- geom_err  out  1  sticky; cleared only by rst.

Behaviour:
- Input path:
  - All five inputs pass through SYNC_STAGES flops.
  - A pclk rising edge is detected when the synchronized pclk is 1 and its previous value was 0.
  - de/rgb are sampled on that same clk, from the same synchronizer stage as pclk. Data must be stable around the pclk rising edge.
- Reset state: all outputs 0, FSM in SEARCH, all counters 0.
- FSM (advances only on detected pclk edges):
  - SEARCH: count DE-low edges; a DE-high edge resets the count. When the count reaches VBLANK_MIN, go to VBLANK. No pixels are emitted in SEARCH, so the receiver never starts mid-frame.
  - VBLANK: on the first DE-high edge, set y=0, x=0, addr=0, emit that pixel, and go to LINE.
  - LINE: each DE-high edge emits a pixel, then x++ and addr++. On a DE-low edge, latch meas_width=x, then go to HBLANK with the blank count set to 1.
  - HBLANK: each DE-low edge increments the blank count. On a DE-high edge, y++, x=0, emit the pixel, and go to LINE. When the blank count reaches VBLANK_MIN, latch meas_height=y+1, pulse frame_done, and go to VBLANK.
- pix_valid:
  - Asserted exactly one clk after the detecting clk.
  - pix_x, pix_y, pix_addr and pix_rgb are registered with it and hold until the next strobe.
- Address:
  - addr is an incremental counter, not a multiplier.
  - At the start of each line, addr = line_base; line_base advances by meas_width at each line end.
  - When widths are correct, addr equals y*H_ACTIVE + x.
- Errors (sticky geom_err):
  - x reaches 1023 while DE is high: x and addr saturate and pixels keep strobing.
  - y reaches 511 in HBLANK: y saturates.
  - Any line end where meas_width != H_ACTIVE.
  - Any frame_done where meas_height != V_ACTIVE.
- locked:
  - Set when a second consecutive frame has correct geometry.
  - Cleared on the same clk as any geom_err event, and on rst.
- Stall: if pclk stops, no state changes occur and no timeout is applied.
- rst mid-line: returns to SEARCH; at least VBLANK_MIN DE-low edges are needed before capture resumes.
- frame_done and pix_valid never occur on the same clk, since each pclk edge produces one event.

Decomposition:
- Shared package lcd_pkg holds:
  - panel constants LCD_H_ACTIVE=480, LCD_V_ACTIVE=272, LCD_H_BLANK=256, LCD_V_BLANK=45;
  - widths X_W=10, Y_W=9, ADDR_W=17;
  - the FSM state encoding (SEARCH, VBLANK, LINE, HBLANK).
- One natural sub-module, lcd_edge_sync: the synchronizer chain plus pclk rising-edge detect, outputting pclk_rise, de_s and rgb_s. The FSM, counters and outputs stay in lcd_de_rx.

Test Plan:
All scenarios use H_ACTIVE=8, V_ACTIVE=4, VBLANK_MIN=16, and pclk = clk/6 unless stated.
- Nominal: two frames of 8x4 active with HBLANK=6 and VBLANK=40 edges, starting in blank. Required: 32 strobes per frame, with addr 0..31 in order, x 0..7 and y 0..3. meas_width=8, meas_height=4, frame_done once per frame, locked=1 after frame 2, geom_err=0.
- Mid-frame start: release rst during line 2 of a frame. Required: no pix_valid until after the next VBLANK. The following frame's first strobe has x=0, y=0, addr=0.
- Short line: line 1 of frame 3 has 7 DE-high pclks. Required: meas_width=7, geom_err=1 and locked=0 on that line end. The next line's first addr is 15.
- Colour capture: pixel (5,2) driven with rgb=3'b101, all others 000. Required: only the strobe with addr=21 carries pix_rgb=101.
- Reset mid-line: assert rst for 1 clk at pixel (3,1). Required: all outputs 0 on the next clk. No strobes occur until 16 DE-low edges, then capture restarts at addr 0.
- Fast pclk limit: pclk = clk/4 with the nominal pattern. Required: identical results to the nominal case, with no missed or duplicated strobes.
